// File: rtl/systolic_pkg.sv
// systolic_pkg
// Shared definitions for the systolic-array drain logic.
// Holds the default array geometry, the drain FSM state encoding and the
// width of one lane slice on the skewed output bus.
package systolic_pkg;

  localparam int ARRAY_SIZE = 4;
  localparam int DATA_WIDTH = 4;
  localparam int LANE_W     = DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/systolic_drain_row_buf.sv
// drain_row_buf
// N x N x W register file that collects one de-skewed result frame.
// Every column has its own write enable and row index, so a single cycle
// can drop each lane's element into a different row. One registered read
// port returns a whole row.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset, clears storage and read port
//   i_we      per-column write enable
//   i_wrRow   per-column destination row index
//   i_wrData  one element per column, column c at [c*W +: W]
//   i_rdEn    load the read register from row i_rdAddr
//   i_rdAddr  row to read
//   o_rdRow   registered row, column c at [c*W +: W]
module drain_row_buf #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N-1:0]                    i_we,
  input  logic [N-1:0][$clog2(N)-1:0]     i_wrRow,
  input  logic [N*W-1:0]                  i_wrData,
  input  logic                            i_rdEn,
  input  logic [$clog2(N)-1:0]            i_rdAddr,
  output logic [N*W-1:0]                  o_rdRow
);

  // Storage indexed [row][column]; a row slice is already packed in the
  // same column order as the output bus.
  logic [N-1:0][N-1:0][W-1:0] r_mem;
  logic [N*W-1:0]             r_rdRow;

  // Each column writes independently, so one cycle of the skewed bus can
  // land its lanes in different rows.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem <= '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (i_we[c]) begin
          r_mem[i_wrRow[c]][c] <= i_wrData[c*W +: W];
        end
      end
    end
  end

  // The read register only reloads when asked, so the presented row stays
  // put while the consumer is stalled or the block is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdRow <= '0;
    end else if (i_rdEn) begin
      r_rdRow <= r_mem[i_rdAddr];
    end
  end

  assign o_rdRow = r_rdRow;

endmodule

// File: rtl/systolic_drain.sv
// systolic_drain
// Receive end of the systolic array's bottom bus. Captures one skewed
// N x N result frame (lane c carries row r at cycle r+c), de-skews it into
// a row buffer and hands whole rows downstream over valid/ready.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   start       marks the cycle in which row 0 of lane 0 is on in_bot
//   in_bot      skewed array output, lane c at [c*W +: W]
//   out_row     de-skewed row, column c at [c*W +: W]
//   out_valid   out_row holds a valid row
//   out_ready   downstream accepts the row when out_valid && out_ready
//   busy        high whenever a frame is being captured or drained
//   frame_done  one-cycle pulse on acceptance of the last row
//   start_err   sticky: start seen while busy, cleared only by reset
module systolic_drain #(
  parameter int ARRAY_SIZE = systolic_pkg::ARRAY_SIZE,
  parameter int DATA_WIDTH = systolic_pkg::LANE_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_bot,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_row,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             start_err
);

  import systolic_pkg::*;

  localparam int N     = ARRAY_SIZE;
  localparam int K_W   = $clog2(2*N);
  localparam int ROW_W = $clog2(N);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(2*N-2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N-1);

  state_t                  r_state;
  state_t                  w_nextState;
  logic [K_W-1:0]          r_k;
  logic [ROW_W-1:0]        r_rdPtr;
  logic                    r_startErr;

  logic                    w_capture;
  logic [K_W-1:0]          w_k;
  logic [31:0]             w_kExt;
  logic [ROW_W-1:0]        w_rdAddr;
  logic                    w_rdEn;
  logic [N-1:0]            w_we;
  logic [N-1:0][ROW_W-1:0] w_wrRow;

  // Next-state and output decode. The start cycle itself is capture step
  // k=0, so IDLE already enables writes when start arrives. The read
  // address looks one step ahead so the registered row lines up with the
  // pointer that will be current next cycle.
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_k         = r_k;
    w_rdAddr    = r_rdPtr;
    out_valid   = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_k         = '0;
          w_nextState = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_capture = 1'b1;
        if (r_k == K_LAST) begin
          w_nextState = ST_DRAIN;
          w_rdAddr    = '0;
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (r_rdPtr == ROW_LAST) begin
            frame_done  = 1'b1;
            w_nextState = ST_IDLE;
          end else begin
            w_rdAddr = r_rdPtr + ROW_W'(1);
          end
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign w_rdEn = (w_nextState == ST_DRAIN);
  assign busy   = (r_state != ST_IDLE);
  assign w_kExt = 32'(w_k);

  // Lane c holds row k-c on capture step k; anything outside 0..N-1 is
  // skew padding and must not reach the buffer.
  for (genvar c = 0; c < N; c++) begin : g_lane
    assign w_we[c]    = w_capture && (w_kExt >= 32'(c)) && (w_kExt < 32'(c + N));
    assign w_wrRow[c] = ROW_W'(w_kExt - 32'(c));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Capture step and drain pointer. Both return to zero when their phase
  // ends so the next frame starts clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k     <= '0;
      r_rdPtr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_k <= K_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (r_k == K_LAST) begin
            r_k     <= '0;
            r_rdPtr <= '0;
          end else begin
            r_k <= r_k + K_W'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            r_rdPtr <= (r_rdPtr == ROW_LAST) ? '0 : r_rdPtr + ROW_W'(1);
          end
        end
        default: begin
          r_k     <= '0;
          r_rdPtr <= '0;
        end
      endcase
    end
  end

  // A start that arrives mid-frame is dropped, but we remember it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_startErr <= 1'b0;
    end else if (start && (r_state != ST_IDLE)) begin
      r_startErr <= 1'b1;
    end
  end

  assign start_err = r_startErr;

  drain_row_buf #(
    .N (N),
    .W (DATA_WIDTH)
  ) u_rowBuf (
    .clk      (clk),
    .reset    (reset),
    .i_we     (w_we),
    .i_wrRow  (w_wrRow),
    .i_wrData (in_bot),
    .i_rdEn   (w_rdEn),
    .i_rdAddr (w_rdAddr),
    .o_rdRow  (out_row)
  );

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Receive end of the systolic array's `out_bot` bus.
- The array emits results skewed: lane c carries row r at cycle r+c, the same stagger the stimulus side applies to `in_top`/`in_left`.
- This block captures one full ARRAY_SIZE x ARRAY_SIZE result frame, de-skews it into a row buffer, and presents whole rows on a valid/ready interface to downstream logic.

Parameters:
- ARRAY_SIZE, 4, lanes per row and rows per frame (N).
- DATA_WIDTH, 4, bits per element (W).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse; marks the cycle in which row 0 of lane 0 is on `in_bot`.
- in_bot  input  N*W  skewed array output; lane c = bits [c*W +: W], lane 0 in the LSBs.
- out_row  output  N*W  de-skewed row; column c = bits [c*W +: W].
- out_valid  output  1  `out_row` holds a valid row.
- out_ready  input  1  downstream accepts the row when out_valid && out_ready.
- busy  output  1  high whenever state != IDLE.
- frame_done  output  1  one-cycle pulse on acceptance of the last row.
- start_err  output  1  sticky flag: start seen while busy.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; row buffer cleared to 0.
- State machine: IDLE, CAPTURE, DRAIN.
- IDLE:
  - start=1 → capture the cycle as k=0 (same-cycle write), go to CAPTURE with k=1 next.
  - start=0 → stay in IDLE.
- CAPTURE:
  - Capture counter k runs 0..2N-2; the skew window is 2N-1 cycles.
  - On cycle k, for each lane c with 0 <= k-c < N, write buf[k-c][c] = in_bot lane c.
  - Lanes outside the window are ignored; garbage on them must not corrupt the buffer.
  - After the k=2N-2 write, go to DRAIN with rd_ptr=0.
- DRAIN:
  - out_valid=1; out_row = buf[rd_ptr], registered output.
  - On a handshake: if rd_ptr=N-1, pulse frame_done, drop out_valid and go to IDLE. Otherwise rd_ptr++.
  - With out_ready=0, out_row and out_valid hold stable; no dropped or duplicated row.
- Latency: with start in cycle 0, out_valid first rises in cycle 2N-1 (7 for N=4).
- Throughput:
  - Minimum N cycles of DRAIN.
  - A new start is accepted no earlier than the cycle after frame_done, i.e. when state is IDLE.
- start while busy: ignored (no restart, no buffer change); start_err goes to 1 and stays there until reset.
- Reset mid-CAPTURE or mid-DRAIN:
  - Next edge returns to IDLE; out_valid, busy, frame_done = 0; partial frame discarded.
  - start_err cleared.
- Counter widths: k uses $clog2(2N) bits, rd_ptr uses $clog2(N) bits. No arithmetic on data; elements are stored unmodified at W bits.
- start and reset asserted together: reset wins.

Decomposition:
- Shared package `systolic_pkg`:
  - ARRAY_SIZE / DATA_WIDTH defaults.
  - State encoding constants ST_IDLE, ST_CAPTURE, ST_DRAIN.
  - Lane-slice helper constant LANE_W.
- One natural sub-module, `drain_row_buf`:
  - N x N x W register file.
  - Per-column write enable with computed row index.
  - Single registered row read port.
- The FSM and counters stay in `systolic_drain`.

Test Plan:
1. Uniform frame, out_ready=1:
   - Stimulus: start in cycle 0; in_bot cycles 0..6 = {0,0,0,1},{0,0,2,1},{0,3,2,1},{4,3,2,1},{4,3,2,0},{4,3,0,0},{4,0,0,0} (MSB lane first).
   - Response: out_valid rises cycle 7; four rows each 16'h4321 on cycles 7..10; frame_done in cycle 10; busy falls cycle 11.
2. Distinct frame:
   - Stimulus: element(r,c) = 4r+c, driven with the skew (lane c gets row k-c at cycle k).
   - Response: rows 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC in order.
3. Backpressure:
   - Stimulus: frame from test 2 with out_ready=0 for 3 cycles after row 1 appears.
   - Response: out_row holds 16'h7654 with out_valid=1 throughout; rows 2 and 3 follow intact.
4. Out-of-window garbage:
   - Stimulus: test 2 with 4'hF driven on lanes outside the capture window.
   - Response: output identical to test 2.
5. start during DRAIN:
   - Stimulus: start pulsed while rows are draining.
   - Response: rows unaffected; start_err=1 and stays 1; a new start after frame_done captures normally.
6. Reset at CAPTURE k=3:
   - Response: next cycle busy=0, out_valid=0, start_err=0.
   - A fresh test-1 frame afterwards yields four rows of 16'h4321.
